// File: rtl/cnt_share_arb.sv
// cnt_share_arb
// Two requesters share one 3-bit up/down counter. A granted requester owns
// the counter for a run of 1-8 steps in its own direction. Contention is
// settled by alternating priority: the requester not granted last wins, and
// FIRST_PRIO wins the first contest after reset.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   req0/req1        requester wants the counter, held until done or withdrawn
//   dir0/dir1        1 = count up, 0 = count down
//   len0/len1        steps in the run, 1-7 literal, 0 means 8
//   gnt0/gnt1        registered grant, high for every step of the run
//   done0/done1      registered one-cycle pulse after a completed run
//   busy             high whenever the arbiter is not idle
//   y                shared counter value
module cnt_share_arb #(
  parameter int FIRST_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       dir0,
  input  logic [2:0] len0,
  input  logic       req1,
  input  logic       dir1,
  input  logic [2:0] len1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic [2:0] y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The pointer holds the last grantee; resetting it to the other requester
  // makes FIRST_PRIO win the first contest.
  localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  state_t     state_r;
  logic [2:0] y_r;
  logic       dir_r;
  logic [3:0] rem_r;
  logic       owner_r;
  logic       last_r;
  logic       gnt0_r;
  logic       gnt1_r;
  logic       done0_r;
  logic       done1_r;
  logic       busy_r;

  logic       grant_s;
  logic       pick_s;
  logic [2:0] pick_len_s;
  logic [3:0] run_len_s;
  logic       owner_req_s;
  logic [2:0] y_next_s;

  // Arbitration and run setup values for the IDLE decision.
  always_comb begin
    grant_s    = req0 | req1;
    pick_s     = 1'b0;
    if (req0 && req1) begin
      pick_s = ~last_r;
    end else if (req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    pick_len_s = pick_s ? len1 : len0;
    if (pick_len_s == 3'd0) begin
      run_len_s = 4'd8;
    end else begin
      run_len_s = {1'b0, pick_len_s};
    end
  end

  // Owner's live request and the next counter value (wraps modulo 8).
  always_comb begin
    owner_req_s = owner_r ? req1 : req0;
    if (dir_r) begin
      y_next_s = y_r + 3'd1;
    end else begin
      y_next_s = y_r - 3'd1;
    end
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      y_r     <= 3'd0;
      dir_r   <= 1'b0;
      rem_r   <= 4'd0;
      owner_r <= 1'b0;
      last_r  <= LAST_RST;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          if (grant_s) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            owner_r <= pick_s;
            gnt0_r  <= ~pick_s;
            gnt1_r  <= pick_s;
            dir_r   <= pick_s ? dir1 : dir0;
            rem_r   <= run_len_s;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (!owner_req_s) begin
            // Withdrawn: no step, no done pulse; DONE still records the owner.
            state_r <= DONE;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
          end else begin
            y_r   <= y_next_s;
            rem_r <= rem_r - 4'd1;
            if (rem_r == 4'd1) begin
              state_r <= DONE;
              gnt0_r  <= 1'b0;
              gnt1_r  <= 1'b0;
              done0_r <= ~owner_r;
              done1_r <= owner_r;
            end else begin
              state_r <= RUN;
            end
          end
        end
        DONE: begin
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          last_r  <= owner_r;
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0  = gnt0_r;
  assign gnt1  = gnt1_r;
  assign done0 = done0_r;
  assign done1 = done1_r;
  assign busy  = busy_r;
  assign y     = y_r;

endmodule

// File: tb/tb_cnt_share_arb.sv
// tb_cnt_share_arb
// Cycle-by-cycle directed vectors for cnt_share_arb: each record gives the
// inputs applied before a rising edge and the outputs expected after it.
// A hand-written sequence covers asynchronous reset in the middle of a run.
module tb_cnt_share_arb;

  logic       clk;
  logic       rst;
  logic       req0, dir0, req1, dir1;
  logic [2:0] len0, len1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [2:0] y;

  int checks;
  int failures;

  typedef struct {
    logic       r0;
    logic       d0;
    logic [2:0] l0;
    logic       r1;
    logic       d1;
    logic [2:0] l1;
    logic [7:0] exp;  // {gnt0, gnt1, done0, done1, busy, y[2:0]}
  } vec_t;

  vec_t vecs[$];

  cnt_share_arb #(.FIRST_PRIO(0)) dut (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .dir0 (dir0),
    .len0 (len0),
    .req1 (req1),
    .dir1 (dir1),
    .len1 (len1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .done0(done0),
    .done1(done1),
    .busy (busy),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pack_exp(input logic g0, input logic g1,
                                          input logic dn0, input logic dn1,
                                          input logic b, input logic [2:0] yv);
    return {g0, g1, dn0, dn1, b, yv};
  endfunction

  task automatic add(input logic r0, input logic d0, input logic [2:0] l0,
                     input logic r1, input logic d1, input logic [2:0] l1,
                     input logic g0, input logic g1, input logic dn0,
                     input logic dn1, input logic b, input logic [2:0] yv);
    vec_t v;
    v.r0 = r0; v.d0 = d0; v.l0 = l0;
    v.r1 = r1; v.d1 = d1; v.l1 = l1;
    v.exp = pack_exp(g0, g1, dn0, dn1, b, yv);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {gnt0, gnt1, done0, done1, busy, y};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got g0g1d0d1b=%b y=%0d, want g0g1d0d1b=%b y=%0d",
               name, act[7:3], act[2:0], exp[7:3], exp[2:0]);
    end
  endtask

  task automatic drive(input logic r0, input logic d0, input logic [2:0] l0,
                       input logic r1, input logic d1, input logic [2:0] l1);
    @(negedge clk);
    req0 = r0; dir0 = d0; len0 = l0;
    req1 = r1; dir1 = d1; len1 = l1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req0 = 1'b0; dir0 = 1'b0; len0 = 3'd0;
    req1 = 1'b0; dir1 = 1'b0; len1 = 3'd0;

    //   r0 d0 l0     r1 d1 l1     g0 g1 dn0 dn1 b  y
    // Single up run of 3 from y=0.
    add(1, 1, 3'd3, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd0);
    add(1, 1, 3'd3, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd1);
    add(1, 1, 3'd3, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd2);
    add(1, 1, 3'd3, 0, 0, 3'd0, 0, 0, 1, 0, 1, 3'd3);
    add(0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd3);
    add(0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd3);
    // Down run of 2 on requester 1: 3 -> 2 -> 1.
    add(0, 0, 3'd0, 1, 0, 3'd2, 0, 1, 0, 0, 1, 3'd3);
    add(0, 0, 3'd0, 1, 0, 3'd2, 0, 1, 0, 0, 1, 3'd2);
    add(0, 0, 3'd0, 1, 0, 3'd2, 0, 0, 0, 1, 1, 3'd1);
    add(0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd1);
    // Down run of 3 with wrap 1 -> 0 -> 7 -> 6; dir/len changed mid-run.
    add(0, 0, 3'd0, 1, 0, 3'd3, 0, 1, 0, 0, 1, 3'd1);
    add(0, 0, 3'd0, 1, 1, 3'd7, 0, 1, 0, 0, 1, 3'd0);
    add(0, 0, 3'd0, 1, 1, 3'd7, 0, 1, 0, 0, 1, 3'd7);
    add(0, 0, 3'd0, 1, 1, 3'd7, 0, 0, 0, 1, 1, 3'd6);
    add(0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd6);
    // Contention, len 2 each, last granted was 1 -> 0, then 1, then 0.
    add(1, 1, 3'd2, 1, 1, 3'd2, 1, 0, 0, 0, 1, 3'd6);
    add(1, 1, 3'd2, 1, 1, 3'd2, 1, 0, 0, 0, 1, 3'd7);
    add(1, 1, 3'd2, 1, 1, 3'd2, 0, 0, 1, 0, 1, 3'd0);
    add(1, 1, 3'd2, 1, 1, 3'd2, 0, 0, 0, 0, 0, 3'd0);
    add(1, 1, 3'd2, 1, 1, 3'd2, 0, 1, 0, 0, 1, 3'd0);
    add(1, 1, 3'd2, 1, 1, 3'd2, 0, 1, 0, 0, 1, 3'd1);
    add(1, 1, 3'd2, 1, 1, 3'd2, 0, 0, 0, 1, 1, 3'd2);
    add(1, 1, 3'd2, 1, 1, 3'd2, 0, 0, 0, 0, 0, 3'd2);
    add(1, 1, 3'd2, 1, 1, 3'd2, 1, 0, 0, 0, 1, 3'd2);
    add(1, 1, 3'd2, 1, 1, 3'd2, 1, 0, 0, 0, 1, 3'd3);
    add(1, 1, 3'd2, 1, 1, 3'd2, 0, 0, 1, 0, 1, 3'd4);
    add(0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd4);
    // len 0 = 8 steps down, back to 4.
    add(1, 0, 3'd0, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd4);
    add(1, 0, 3'd0, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd3);
    add(1, 0, 3'd0, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd2);
    add(1, 0, 3'd0, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd1);
    add(1, 0, 3'd0, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd0);
    add(1, 0, 3'd0, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd7);
    add(1, 0, 3'd0, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd6);
    add(1, 0, 3'd0, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd5);
    add(1, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 0, 1, 3'd4);
    add(0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd4);
    // Abort after 2 of 5 steps; requester 1 waits and is served next.
    add(1, 1, 3'd5, 0, 0, 3'd0, 1, 0, 0, 0, 1, 3'd4);
    add(1, 1, 3'd5, 1, 1, 3'd1, 1, 0, 0, 0, 1, 3'd5);
    add(1, 1, 3'd5, 1, 1, 3'd1, 1, 0, 0, 0, 1, 3'd6);
    add(0, 1, 3'd5, 1, 1, 3'd1, 0, 0, 0, 0, 1, 3'd6);
    add(0, 0, 3'd0, 1, 1, 3'd1, 0, 0, 0, 0, 0, 3'd6);
    add(0, 0, 3'd0, 1, 1, 3'd1, 0, 1, 0, 0, 1, 3'd6);
    add(0, 0, 3'd0, 1, 1, 3'd1, 0, 0, 0, 1, 1, 3'd7);
    add(0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd7);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r0, vecs[i].d0, vecs[i].l0, vecs[i].r1, vecs[i].d1, vecs[i].l1);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Async reset mid-run: start an up run of 5 from y=7, take two steps.
    drive(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0);
    check("mid_grant", pack_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7));
    drive(1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 3'd2);
    check("mid_step1", pack_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
    drive(1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 3'd2);
    check("mid_step2", pack_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 8'h00);
    // Hold reset across an edge: still reset values, no done pulse.
    @(posedge clk);
    #1;
    check("rst_hold", 8'h00);
    @(negedge clk);
    rst = 1'b0;
    // Both requesting after reset: FIRST_PRIO=0 wins, len 2 up from 0.
    req0 = 1'b1; dir0 = 1'b1; len0 = 3'd2;
    @(posedge clk);
    #1;
    check("post_rst_gnt0", pack_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0));
    drive(1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd2);
    check("post_rst_s1", pack_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
    drive(1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd2);
    check("post_rst_done0", pack_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2));
    drive(1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd2);
    check("post_rst_idle", pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2));
    drive(1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd2);
    check("post_rst_gnt1", pack_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
